bridge_req_scheduler: RTL
=========================

// Module: bridge_req_scheduler
// PURPOSE
//  Round-robin scheduler that shares one BRIDGE (DRAM<->SD transfer engine) between NREQ requesters.
//  Accepts one transfer request at a time and drives the bridge's single-cycle in_valid command.
//  Collects the bridge's 8-byte out_valid burst into a 64-bit word and returns it on a shared response channel.
//  Watchdog flags a bridge that never answers.
// PARAMETERS
//  NREQ         2      number of requesters (>=2); IDW = $clog2(NREQ)
//  TIMEOUT_CYC  65535  cycles from command issue to first out_valid before timeout_err is set
// PORTS
//  clk           in   1          clock
//  rst_n         in   1          reset, asynchronous, active-low
//  req_valid     in   NREQ       per-requester request valid
//  req_ready     out  NREQ       per-requester accept; one-hot or zero
//  req_dir       in   NREQ       1: SD->DRAM, 0: DRAM->SD
//  req_addr_dram in   NREQ*13    packed; requester i occupies [13*i+12:13*i]
//  req_addr_sd   in   NREQ*16    packed; requester i occupies [16*i+15:16*i]
//  resp_valid    out  1          response valid
//  resp_ready    in   1          response consumer ready
//  resp_id       out  IDW        index of the requester that owns the response
//  resp_data     out  64         transferred data; first bridge byte in [63:56]
//  br_in_valid   out  1          bridge command strobe; exactly 1 cycle per request
//  br_direction  out  1          bridge direction
//  br_addr_dram  out  13         bridge DRAM address
//  br_addr_sd    out  16         bridge SD address
//  br_out_valid  in   1          bridge output byte valid
//  br_out_data   in   8          bridge output byte
//  busy          out  1          high in every state except IDLE
//  timeout_err   out  1          sticky; cleared only by reset
//  protocol_err  out  1          sticky; set by br_out_valid outside WAIT; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr = 0, byte_cnt = 0, wd_cnt = 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: grant = first i with req_valid[i], scanning from rr_ptr upward and wrapping at NREQ.
//    - req_ready[grant] = 1 combinationally; all other bits 0.
//    - On the handshake: latch dir and both addresses, set id = grant, set rr_ptr = grant+1 mod NREQ, go to ISSUE.
//  - ISSUE (one cycle): br_in_valid = 1; br_* carry the latched fields (flopped outputs).
//    - br_* are 0 in all other states. Next state is WAIT; wd_cnt = 0; byte_cnt = 0.
//  - WAIT: each cycle with br_out_valid: data <= {data[55:0], br_out_data}; byte_cnt += 1.
//    - Gaps in br_out_valid hold byte_cnt.
//    - When the 8th byte is captured (byte_cnt == 7 && br_out_valid), go to RESP.
//    - wd_cnt counts WAIT cycles until the first byte arrives, then freezes.
//    - If wd_cnt reaches TIMEOUT_CYC, timeout_err <= 1; the FSM keeps waiting (no abort, no bridge reset).
//  - RESP: resp_valid = 1, resp_id and resp_data are stable.
//    - Leave to IDLE on resp_valid && resp_ready.
//    - Earliest new accept is the cycle after that, so back-to-back bridge commands are at least 3 cycles apart.
//    - This guarantees the bridge is back in IDLE.
//  - req_ready is 0 in ISSUE, WAIT and RESP; the scheduler never queues a second request.
//  - br_out_valid in IDLE, ISSUE or RESP: the byte is ignored and protocol_err <= 1.
//  - Simultaneous req_valid from all requesters: strict rotation, so no requester waits more than NREQ-1 grants.
//  - A requester dropping req_valid before the grant is legal and is not remembered.
//  - Async reset mid-transfer returns to IDLE immediately and drops br_in_valid and resp_valid.
//    - A partial bridge burst after reset sets protocol_err.
// STRUCTURE
//  Shared package bridge_pkg:
//  - state enum {IDLE, ISSUE, WAIT, RESP}
//  - widths DRAM_AW = 13, SD_AW = 16, BURST_BYTES = 8
//  Sub-module: rr_arbiter (NREQ, req vector, rr_ptr -> one-hot grant + index); purely combinational.
//  Everything else is inline: FSM, capture shift register, watchdog counter.
// TESTING
//  1. Req0 only, dir=0, dram=13'h1A2B, sd=16'h00F0.
//     -> One br_in_valid pulse carrying those fields; bridge model returns bytes 01..08.
//     -> resp_data = 64'h0102030405060708, resp_id = 0.
//  2. Req0 and req1 both held valid from reset.
//     -> Grants alternate 0,1,0,1 over 4 transfers; only one br_in_valid per transfer.
//  3. Bridge burst with 3-cycle gaps between bytes.
//     -> Same data as a gapless burst; exactly 8 bytes captured.
//  4. resp_ready held low for 20 cycles.
//     -> resp_valid and resp_data stable; req_ready = 0 throughout; no br_in_valid.
//  5. TIMEOUT_CYC = 16; bridge silent for 40 cycles, then returns a burst.
//     -> timeout_err = 1 at issue+16 and stays 1; the response is still delivered.
//  6. Stray br_out_valid in IDLE -> protocol_err = 1; async reset mid-WAIT -> all outputs 0 and busy = 0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and widths for the bridge request scheduler.
// Holds the FSM state encoding, address widths and burst length.
package bridge_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int DRAM_AW     = 13;
  localparam int SD_AW       = 16;
  localparam int BURST_BYTES = 8;
  localparam int BCW         = $clog2(BURST_BYTES);
  localparam int DW          = 8 * BURST_BYTES;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans i_req from i_ptr upward,
// wrapping at NREQ. Ports: i_req, i_ptr -> o_gnt (one-hot), o_idx, o_any.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);
  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/bridge_req_scheduler.sv
// Round-robin scheduler sharing one DRAM<->SD bridge among NREQ requesters.
// Ports: req_* (requesters), resp_* (response), br_* (bridge), busy/errors.
module bridge_req_scheduler
  import bridge_pkg::*;
#(
  parameter  int NREQ        = 2,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*13-1:0]    req_addr_dram,
  input  logic [NREQ*16-1:0]    req_addr_sd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [63:0]           resp_data,
  output logic                  br_in_valid,
  output logic                  br_direction,
  output logic [12:0]           br_addr_dram,
  output logic [15:0]           br_addr_sd,
  input  logic                  br_out_valid,
  input  logic [7:0]            br_out_data,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  protocol_err
);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     w_idx;
  logic [NREQ-1:0]    w_gnt;
  logic               w_any;
  logic               w_hs;
  logic               w_byte;
  logic               w_last;
  logic               w_wd_run;
  logic [BCW-1:0]     r_bcnt;
  logic [WDW-1:0]     r_wd;
  logic [DW-1:0]      r_data;
  logic               r_br_v;
  logic               r_br_dir;
  logic [DRAM_AW-1:0] r_br_dram;
  logic [SD_AW-1:0]   r_br_sd;
  logic               r_to;
  logic               r_perr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_hs   = (r_state == IDLE) && w_any;
  assign w_byte = (r_state == WAIT) && br_out_valid;
  assign w_last = w_byte && (r_bcnt == BCW'(BURST_BYTES - 1));

  // Watchdog runs from the issue cycle until the first byte shows up.
  assign w_wd_run = (r_state == ISSUE) ||
                    ((r_state == WAIT) && (r_bcnt == '0) && !br_out_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_last) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_bcnt    <= '0;
      r_wd      <= '0;
      r_data    <= '0;
      r_br_v    <= 1'b0;
      r_br_dir  <= 1'b0;
      r_br_dram <= '0;
      r_br_sd   <= '0;
      r_to      <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      // Command fields are live only during the single ISSUE cycle.
      r_br_v    <= w_hs;
      r_br_dir  <= w_hs ? req_dir[w_idx] : 1'b0;
      r_br_dram <= w_hs ?
        req_addr_dram[int'(w_idx)*DRAM_AW +: DRAM_AW] : '0;
      r_br_sd   <= w_hs ?
        req_addr_sd[int'(w_idx)*SD_AW +: SD_AW] : '0;
      if (w_hs) begin
        r_id   <= w_idx;
        r_ptr  <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
        r_wd   <= '0;
        r_bcnt <= '0;
      end
      if (w_wd_run && (r_wd != WDW'(TIMEOUT_CYC))) begin
        r_wd <= r_wd + WDW'(1);
        if (r_wd == WDW'(TIMEOUT_CYC - 1)) r_to <= 1'b1;
      end
      if (w_byte) begin
        r_data <= {r_data[DW-9:0], br_out_data};
        r_bcnt <= r_bcnt + BCW'(1);
      end
      if (br_out_valid && (r_state != WAIT)) r_perr <= 1'b1;
    end
  end

  assign req_ready    = (r_state == IDLE) ? w_gnt : '0;
  assign resp_valid   = (r_state == RESP);
  assign resp_id      = r_id;
  assign resp_data    = r_data;
  assign br_in_valid  = r_br_v;
  assign br_direction = r_br_dir;
  assign br_addr_dram = r_br_dram;
  assign br_addr_sd   = r_br_sd;
  assign busy         = (r_state != IDLE);
  assign timeout_err  = r_to;
  assign protocol_err = r_perr;
endmodule
